// File: rtl/spm_serial_mult.sv
// spm_serial_mult: unsigned serial-parallel multiplier, P = MP*MC after 2N busy cycles
// Ports: clk rising-edge clock; rst synchronous active-low reset;
//        MP/MC operands sampled on the accepting start edge; start level request (IDLE only);
//        P 2N-bit product register; done one-cycle completion pulse.
module spm_serial_mult #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   MP,
  input  logic [N-1:0]   MC,
  input  logic           start,
  output logic [2*N-1:0] P,
  output logic           done
);
  localparam int CW = $clog2(2 * N);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] mc_q, mc_d, mp_q, mp_d, s_q, s_d, c_q, c_d;
  logic [N-1:0] pp, s_up, s_n, c_n;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The MP register shifts in zeros, so its LSB is the flush bit once all N bits are consumed.
  assign pp   = mc_q & {N{mp_q[0]}};
  assign s_up = {1'b0, s_q[N-1:1]};
  assign s_n  = pp ^ s_up ^ c_q;
  assign c_n  = (pp & s_up) | (pp & c_q) | (s_up & c_q);
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    s_d     = s_q;
    c_d     = c_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      mc_d    = MC;
      mp_d    = MP;
      s_d     = '0;
      c_d     = '0;
      p_d     = '0;
      cnt_d   = '0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      s_d     = s_n;
      c_d     = c_n;
      p_d     = {s_n[0], p_q[2*N-1:1]};
      mp_d    = mp_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(2 * N - 1)) ? DONE : BUSY;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      s_q     <= s_d;
      c_q     <= c_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end
  assign P    = p_q;
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_spm_serial_mult.sv
// tb_spm_serial_mult: randomized check of spm_serial_mult against a product/latency model
module tb_spm_serial_mult;
  logic        clk, rst, start, done;
  logic [31:0] MP, MC;
  logic [63:0] P;
  spm_serial_mult dut (.clk(clk), .rst(rst), .MP(MP), .MC(MC), .start(start), .P(P), .done(done));
  initial clk = 0;
  always #5 clk = ~clk;
  int          checks = 0, errors = 0;
  int          m_left = 0;
  logic        m_done = 0, m_on = 0;
  logic [63:0] m_p = 0, m_exp = 0;
  logic        pin_en = 0;
  logic [63:0] pin_p = 0;
  // Model: an accepted start yields MP*MC and a done pulse exactly 64 edges later, then idle.
  always @(posedge clk) begin
    if (!rst) begin
      m_left <= 0;
      m_done <= 0;
      m_p    <= 0;
      m_on   <= 1;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1;
        m_p    <= m_exp;
      end
    end else if (start) begin
      m_exp  <= 64'(MP) * 64'(MC);
      m_p    <= 0;
      m_left <= 64;
    end
  end
  always @(negedge clk) begin
    if (m_on) begin
      checks++;
      if (done !== m_done) begin
        errors++;
        $display("FAIL done t=%0t got %b want %b", $time, done, m_done);
      end
      if (m_left == 0) begin
        checks++;
        if (P !== m_p) begin
          errors++;
          $display("FAIL p_model t=%0t got %h want %h", $time, P, m_p);
        end
      end
      if (m_done && pin_en) begin
        checks++;
        if (P !== pin_p) begin
          errors++;
          $display("FAIL p_literal t=%0t got %h want %h", $time, P, pin_p);
        end
      end
    end
  end
  task automatic wait_done();
    for (int k = 0; k < 200 && !m_done; k++) @(negedge clk);
  endtask
  task automatic op(input logic [31:0] mp, input logic [31:0] mc, input logic [63:0] lit);
    @(negedge clk);
    MP = mp; MC = mc; start = 1; pin_p = lit; pin_en = 1;
    @(negedge clk);
    start = 0; MP = $urandom; MC = $urandom;
    wait_done();
    @(negedge clk);
    pin_en = 0;
  endtask
  initial begin
    rst = 0; start = 0; MP = 0; MC = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (50) @(negedge clk);
    op(32'd2, 32'd3, 64'h6);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    op(32'd0, 32'h12345678, 64'h0);
    op(32'd1, 32'h80000000, 64'h80000000);
    @(negedge clk);
    MP = 5; MC = 7; start = 1; pin_p = 35; pin_en = 1;
    @(negedge clk);
    MP = 9; MC = 9;
    wait_done();
    @(negedge clk);
    pin_p = 81;
    @(negedge clk);
    wait_done();
    @(negedge clk);
    start = 0; pin_en = 0;
    repeat (3) @(negedge clk);
    MP = 123; MC = 456; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    repeat (80) @(negedge clk);
    op(32'd10, 32'd10, 64'd100);
    start = 1;
    for (int n = 0; n < 1000; n++) begin
      do begin
        @(negedge clk);
        MP = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
        MC = $urandom;
      end while (!m_done);
    end
    start = 0;
    repeat (70) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
